// File: rtl/ahb_burst_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ahb_burst_tracker
// Purpose  : AHB-Lite slave-side burst tracker; one registered beat
//            descriptor per accepted beat plus protocol error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_burst_tracker #(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int IDX_W      = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hburst,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic              hready,
  output logic              beat_valid,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [IDX_W-1:0]  beat_idx,
  output logic              beat_first,
  output logic              beat_last,
  output logic              beat_write,
  output logic              burst_active,
  output logic              err_seq,
  output logic              err_size,
  output logic              err_term
);

  localparam int         C_LEN_W        = IDX_W + 1;
  localparam logic [2:0] C_MAX_SIZE     = 3'($clog2(DATA_BYTES));
  localparam logic [2:0] C_BURST_SINGLE = 3'd0;
  localparam logic [2:0] C_BURST_INCR   = 3'd1;
  localparam logic [1:0] C_TRANS_BUSY   = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIXED = 2'd1,
    S_OPEN  = 2'd2
  } state_t;

  state_t               r_state, w_state_nx;
  logic [2:0]           r_size, w_size_nx;
  logic [C_LEN_W-1:0]   r_len, w_len_nx;
  logic                 r_wrap, w_wrap_nx;
  logic                 r_write, w_write_nx;
  logic                 r_done, w_done_nx;
  logic [IDX_W-1:0]     r_idx, w_idx_nx;
  logic [ADDR_W-1:0]    r_exp, w_exp_nx;

  logic                 w_valid_nx, w_first_nx, w_last_nx, w_bwrite_nx;
  logic [ADDR_W-1:0]    w_addr_nx;
  logic [IDX_W-1:0]     w_bidx_nx;
  logic                 w_eseq_nx, w_esize_nx, w_eterm_nx;

  logic                 w_acc;
  logic [C_LEN_W-1:0]   w_len_dec;
  logic                 w_wrap_dec;
  logic [2:0]           w_sel_size;
  logic [C_LEN_W-1:0]   w_sel_len;
  logic                 w_sel_wrap;
  logic [ADDR_W-1:0]    w_incr, w_mask, w_sum, w_next;
  logic [IDX_W-1:0]     w_idx_inc;
  logic                 w_seq_last;

  assign w_acc = hsel && hready && htrans[1];

  always_comb begin
    w_len_dec = C_LEN_W'(16);
    case (hburst)
      3'd0:       w_len_dec = C_LEN_W'(1);
      3'd1:       w_len_dec = C_LEN_W'(0);
      3'd2, 3'd3: w_len_dec = C_LEN_W'(4);
      3'd4, 3'd5: w_len_dec = C_LEN_W'(8);
      default:    w_len_dec = C_LEN_W'(16);
    endcase
  end
  assign w_wrap_dec = !hburst[0] && (hburst != C_BURST_SINGLE);

  // NONSEQ derives its expectation from the new burst's attributes, SEQ from the latched ones
  assign w_sel_size = htrans[0] ? r_size : hsize;
  assign w_sel_len  = htrans[0] ? r_len  : w_len_dec;
  assign w_sel_wrap = htrans[0] ? r_wrap : w_wrap_dec;
  assign w_incr     = ADDR_W'(1) << w_sel_size;
  assign w_mask     = (ADDR_W'(w_sel_len) << w_sel_size) - ADDR_W'(1);
  assign w_sum      = haddr + w_incr;
  assign w_next     = w_sel_wrap ? ((haddr & ~w_mask) | (w_sum & w_mask)) : w_sum;

  assign w_idx_inc  = ((r_state == S_OPEN) && (&r_idx)) ? r_idx : r_idx + 1'b1;
  assign w_seq_last = (r_state == S_FIXED) &&
                      ({1'b0, w_idx_inc} == C_LEN_W'(r_len - 1'b1));

  always_comb begin
    w_state_nx  = r_state;
    w_size_nx   = r_size;
    w_len_nx    = r_len;
    w_wrap_nx   = r_wrap;
    w_write_nx  = r_write;
    w_done_nx   = r_done;
    w_idx_nx    = r_idx;
    w_exp_nx    = r_exp;
    w_valid_nx  = beat_valid;
    w_addr_nx   = beat_addr;
    w_bidx_nx   = beat_idx;
    w_first_nx  = beat_first;
    w_last_nx   = beat_last;
    w_bwrite_nx = beat_write;
    w_eseq_nx   = err_seq;
    w_esize_nx  = err_size;
    w_eterm_nx  = err_term;
    if (hready) begin
      w_valid_nx = 1'b0;
      w_eseq_nx  = 1'b0;
      w_esize_nx = 1'b0;
      w_eterm_nx = 1'b0;
      if (w_acc) begin
        if (hsize > C_MAX_SIZE) begin
          w_esize_nx = 1'b1;
        end else if (!htrans[0]) begin
          w_eterm_nx  = (r_state == S_FIXED) && !r_done;
          w_size_nx   = hsize;
          w_len_nx    = w_len_dec;
          w_wrap_nx   = w_wrap_dec;
          w_write_nx  = hwrite;
          w_idx_nx    = '0;
          w_exp_nx    = w_next;
          w_done_nx   = (hburst == C_BURST_SINGLE);
          w_state_nx  = (hburst == C_BURST_INCR) ? S_OPEN : S_FIXED;
          w_valid_nx  = 1'b1;
          w_addr_nx   = haddr;
          w_bidx_nx   = '0;
          w_first_nx  = 1'b1;
          w_last_nx   = (hburst == C_BURST_SINGLE);
          w_bwrite_nx = hwrite;
        end else if ((r_state != S_IDLE) && !r_done) begin
          w_eseq_nx   = (haddr != r_exp);
          w_idx_nx    = w_idx_inc;
          w_exp_nx    = w_next;
          w_valid_nx  = 1'b1;
          w_addr_nx   = haddr;
          w_bidx_nx   = w_idx_inc;
          w_first_nx  = 1'b0;
          w_last_nx   = w_seq_last;
          w_bwrite_nx = r_write;
          if (w_seq_last) begin
            w_state_nx = S_IDLE;
            w_done_nx  = 1'b1;
          end
        end else if (r_done) begin
          w_eterm_nx = 1'b1;
        end else begin
          w_eseq_nx = 1'b1;
        end
      end else if (!(hsel && (htrans == C_TRANS_BUSY))) begin
        w_eterm_nx = (r_state == S_FIXED) && !r_done;
        w_state_nx = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_size     <= '0;
      r_len      <= '0;
      r_wrap     <= 1'b0;
      r_write    <= 1'b0;
      r_done     <= 1'b0;
      r_idx      <= '0;
      r_exp      <= '0;
      beat_valid <= 1'b0;
      beat_addr  <= '0;
      beat_idx   <= '0;
      beat_first <= 1'b0;
      beat_last  <= 1'b0;
      beat_write <= 1'b0;
      err_seq    <= 1'b0;
      err_size   <= 1'b0;
      err_term   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_size     <= w_size_nx;
      r_len      <= w_len_nx;
      r_wrap     <= w_wrap_nx;
      r_write    <= w_write_nx;
      r_done     <= w_done_nx;
      r_idx      <= w_idx_nx;
      r_exp      <= w_exp_nx;
      beat_valid <= w_valid_nx;
      beat_addr  <= w_addr_nx;
      beat_idx   <= w_bidx_nx;
      beat_first <= w_first_nx;
      beat_last  <= w_last_nx;
      beat_write <= w_bwrite_nx;
      err_seq    <= w_eseq_nx;
      err_size   <= w_esize_nx;
      err_term   <= w_eterm_nx;
    end
  end

  assign burst_active = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ahb_burst_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_burst_tracker
// Purpose  : Directed self-checking bench for ahb_burst_tracker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_burst_tracker;
  localparam int ADDR_W     = 32;
  localparam int DATA_BYTES = 4;
  localparam int IDX_W      = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              hsel = 1'b0;
  logic [ADDR_W-1:0] haddr = '0;
  logic [1:0]        htrans = 2'd0;
  logic [2:0]        hburst = 3'd0;
  logic [2:0]        hsize = 3'd0;
  logic              hwrite = 1'b0;
  logic              hready = 1'b1;
  logic              beat_valid, beat_first, beat_last, beat_write, burst_active;
  logic [ADDR_W-1:0] beat_addr;
  logic [IDX_W-1:0]  beat_idx;
  logic              err_seq, err_size, err_term;

  logic [ADDR_W+IDX_W+2:0]  beat;
  logic [2:0]               errs;
  logic [ADDR_W+IDX_W+7:0]  all_out;
  assign beat    = {beat_valid, beat_addr, beat_idx, beat_first, beat_last};
  assign errs    = {err_seq, err_size, err_term};
  assign all_out = {beat, beat_write, burst_active, errs};

  int n_pass  = 0;
  int n_total = 0;

  ahb_burst_tracker #(.ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rstn(rstn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hburst(hburst), .hsize(hsize), .hwrite(hwrite), .hready(hready),
    .beat_valid(beat_valid), .beat_addr(beat_addr), .beat_idx(beat_idx),
    .beat_first(beat_first), .beat_last(beat_last), .beat_write(beat_write),
    .burst_active(burst_active), .err_seq(err_seq), .err_size(err_size),
    .err_term(err_term)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic [2:0] b,
                       input logic [2:0] s, input logic w, input logic r);
    hsel = 1'b1; htrans = t; haddr = a; hburst = b; hsize = s; hwrite = w; hready = r;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; hsel = 1'b0; htrans = 2'd0; hready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (all_out !== '0) $display("FAIL reset: outputs=%h required 0", all_out);
    else n_pass++;
    rstn = 1'b1;
  endtask

  task automatic test_wrap4();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'h1000 | ((32'h8 + 32'(4 * i)) & 32'hF);
      drive(i == 0 ? 2'd2 : 2'd3, a, 3'd2, 3'd2, 1'b1, 1'b1);
      n_total++;
      if ({beat, beat_write, errs} !== {1'b1, a, 4'(i), i == 0, i == 3, 1'b1, 3'b000})
        $display("FAIL wrap4 beat%0d: got %h required %h", i, {beat, beat_write, errs},
                 {1'b1, a, 4'(i), i == 0, i == 3, 1'b1, 3'b000});
      else n_pass++;
    end
    n_total++;
    if (burst_active !== 1'b0) $display("FAIL wrap4 active: got %b required 0", burst_active);
    else n_pass++;
    drive(2'd3, 32'h1008, 3'd2, 3'd2, 1'b1, 1'b1);
    n_total++;
    if ({beat_valid, errs} !== 4'b0001)
      $display("FAIL seq_after_done: valid/errs=%b required 0001", {beat_valid, errs});
    else n_pass++;
    drive(2'd0, 32'h0, 3'd0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic test_incr8_stall();
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 32'h200 + 32'(2 * i);
      drive(i == 0 ? 2'd2 : 2'd3, a, 3'd5, 3'd1, 1'b0, 1'b1);
      n_total++;
      if ({beat, beat_write, errs} !== {1'b1, a, 4'(i), i == 0, i == 7, 1'b0, 3'b000})
        $display("FAIL incr8 beat%0d: got %h required %h", i, {beat, beat_write, errs},
                 {1'b1, a, 4'(i), i == 0, i == 7, 1'b0, 3'b000});
      else n_pass++;
      if (i == 2) begin
        for (int k = 0; k < 2; k++) begin
          drive(2'd3, 32'h206, 3'd5, 3'd1, 1'b0, 1'b0);
          n_total++;
          if ({beat, errs} !== {1'b1, 32'h204, 4'd2, 1'b0, 1'b0, 3'b000})
            $display("FAIL incr8 stall%0d: got %h required %h", k, {beat, errs},
                     {1'b1, 32'h204, 4'd2, 1'b0, 1'b0, 3'b000});
          else n_pass++;
        end
      end
      if (i == 5) begin
        drive(2'd1, 32'h20C, 3'd5, 3'd1, 1'b0, 1'b1);
        n_total++;
        if ({beat_valid, burst_active, errs} !== 5'b01000)
          $display("FAIL incr8 busy: valid/active/errs=%b required 01000",
                   {beat_valid, burst_active, errs});
        else n_pass++;
      end
    end
  endtask

  task automatic test_wrap16();
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      a = 32'h3F0 | 32'((5 + i) % 16);
      drive(i == 0 ? 2'd2 : 2'd3, a, 3'd6, 3'd0, 1'b1, 1'b1);
      n_total++;
      if ({beat, errs} !== {1'b1, a, 4'(i), i == 0, i == 15, 3'b000})
        $display("FAIL wrap16 beat%0d: got %h required %h", i, {beat, errs},
                 {1'b1, a, 4'(i), i == 0, i == 15, 3'b000});
      else n_pass++;
    end
  endtask

  task automatic test_early_term();
    drive(2'd2, 32'h40, 3'd3, 3'd2, 1'b0, 1'b1);
    drive(2'd3, 32'h44, 3'd3, 3'd2, 1'b0, 1'b1);
    n_total++;
    if ({beat, errs} !== {1'b1, 32'h44, 4'd1, 1'b0, 1'b0, 3'b000})
      $display("FAIL term beat1: got %h", {beat, errs});
    else n_pass++;
    drive(2'd2, 32'h80, 3'd3, 3'd2, 1'b0, 1'b1);
    n_total++;
    if ({beat, errs} !== {1'b1, 32'h80, 4'd0, 1'b1, 1'b0, 3'b001})
      $display("FAIL term restart: got %h required %h", {beat, errs},
               {1'b1, 32'h80, 4'd0, 1'b1, 1'b0, 3'b001});
    else n_pass++;
    for (int i = 1; i < 4; i++) begin
      drive(2'd3, 32'h80 + 32'(4 * i), 3'd3, 3'd2, 1'b0, 1'b1);
      n_total++;
      if ({beat, errs} !== {1'b1, 32'h80 + 32'(4 * i), 4'(i), 1'b0, i == 3, 3'b000})
        $display("FAIL term new beat%0d: got %h", i, {beat, errs});
      else n_pass++;
    end
  endtask

  task automatic test_seq_err();
    drive(2'd2, 32'h20, 3'd4, 3'd2, 1'b1, 1'b1);
    drive(2'd3, 32'h30, 3'd4, 3'd2, 1'b1, 1'b1);
    n_total++;
    if ({beat, errs} !== {1'b1, 32'h30, 4'd1, 1'b0, 1'b0, 3'b100})
      $display("FAIL seqerr mismatch: got %h required %h", {beat, errs},
               {1'b1, 32'h30, 4'd1, 1'b0, 1'b0, 3'b100});
    else n_pass++;
    drive(2'd3, 32'h34, 3'd4, 3'd2, 1'b1, 1'b1);
    n_total++;
    if ({beat, errs} !== {1'b1, 32'h34, 4'd2, 1'b0, 1'b0, 3'b000})
      $display("FAIL seqerr follow: got %h required %h", {beat, errs},
               {1'b1, 32'h34, 4'd2, 1'b0, 1'b0, 3'b000});
    else n_pass++;
    drive(2'd0, 32'h0, 3'd0, 3'd0, 1'b0, 1'b1);
    n_total++;
    if ({beat_valid, burst_active, errs} !== 5'b00001)
      $display("FAIL seqerr idle_abort: valid/active/errs=%b required 00001",
               {beat_valid, burst_active, errs});
    else n_pass++;
  endtask

  task automatic test_open();
    int e;
    drive(2'd2, 32'h500, 3'd1, 3'd2, 1'b0, 1'b1);
    for (int i = 1; i < 18; i++) begin
      if (i == 3) drive(2'd1, 32'h50C, 3'd1, 3'd2, 1'b0, 1'b1);
      drive(2'd3, 32'h500 + 32'(4 * i), 3'd1, 3'd2, 1'b0, 1'b1);
      e = (i > 15) ? 15 : i;
      n_total++;
      if ({beat, burst_active, errs} !== {1'b1, 32'h500 + 32'(4 * i), 4'(e), 1'b0, 1'b0, 1'b1, 3'b000})
        $display("FAIL open beat%0d: got %h", i, {beat, burst_active, errs});
      else n_pass++;
    end
    drive(2'd0, 32'h0, 3'd0, 3'd0, 1'b0, 1'b1);
    n_total++;
    if ({beat_valid, burst_active, errs} !== 5'b00000)
      $display("FAIL open end: valid/active/errs=%b required 00000", {beat_valid, burst_active, errs});
    else n_pass++;
  endtask

  task automatic test_size_and_reset();
    drive(2'd2, 32'h100, 3'd0, 3'd3, 1'b0, 1'b1);
    n_total++;
    if ({beat_valid, burst_active, errs} !== 5'b00010)
      $display("FAIL size: valid/active/errs=%b required 00010", {beat_valid, burst_active, errs});
    else n_pass++;
    drive(2'd2, 32'h100, 3'd3, 3'd2, 1'b0, 1'b1);
    drive(2'd3, 32'h104, 3'd3, 3'd2, 1'b0, 1'b1);
    n_total++;
    if ({beat, burst_active} !== {1'b1, 32'h104, 4'd1, 1'b0, 1'b0, 1'b1})
      $display("FAIL prereset beat: got %h", {beat, burst_active});
    else n_pass++;
    rstn = 1'b0;
    #1;
    n_total++;
    if (all_out !== '0) $display("FAIL async reset: outputs=%h required 0", all_out);
    else n_pass++;
    @(posedge clk); #1;
    rstn = 1'b1;
    drive(2'd3, 32'h108, 3'd3, 3'd2, 1'b0, 1'b1);
    n_total++;
    if ({beat_valid, burst_active, errs} !== 5'b00100)
      $display("FAIL seq after reset: valid/active/errs=%b required 00100",
               {beat_valid, burst_active, errs});
    else n_pass++;
    drive(2'd0, 32'h0, 3'd0, 3'd0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_wrap4();
    test_incr8_stall();
    test_wrap16();
    test_early_term();
    test_seq_err();
    test_open();
    test_size_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_burst_tracker.md
Name: ahb_burst_tracker

Overview:
- Parametrised AHB-Lite slave-side burst tracker for the cache front end.
- Decodes every AHB burst type: SINGLE, INCR, and INCR/WRAP of 4, 8 and 16 beats, with any legal HSIZE up to the bus width.
- Emits one registered beat descriptor per accepted beat: address, beat index, first/last flags, direction.
- Checks SEQ addresses against the expected sequence; flags size errors, early termination and over-length bursts.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_BYTES, 4, data bus width in bytes (power of two, 1 to 16).
- IDX_W, 4, beat index width (must hold 15).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- haddr  in  ADDR_W  address-phase address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hburst  in  3  SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7
- hsize  in  3  log2 of transfer bytes
- hwrite  in  1  direction
- hready  in  1  bus ready; a transfer is accepted when hsel and hready are 1 and htrans is NONSEQ or SEQ
- beat_valid  out  1  data-phase beat descriptor valid
- beat_addr  out  ADDR_W  address of current data-phase beat
- beat_idx  out  IDX_W  beat number within burst, 0 = first
- beat_first  out  1  first beat of burst
- beat_last  out  1  final beat of a fixed-length burst or SINGLE
- beat_write  out  1  latched hwrite
- burst_active  out  1  tracker is inside a burst (state not IDLE)
- err_seq  out  1  one-cycle pulse: SEQ address mismatch or SEQ with no burst open
- err_size  out  1  one-cycle pulse: hsize greater than log2(DATA_BYTES)
- err_term  out  1  one-cycle pulse: fixed burst ended early, or SEQ beyond burst length

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous, active-low. While rstn=0, all outputs and all internal registers are 0 and the state is IDLE.
- Reset mid-burst: the burst is discarded; after release, the next accepted transfer must be NONSEQ.
- Timing: all outputs are registered. The descriptor for a transfer accepted at edge N is valid from edge N until the next edge at which hready=1. While hready=0 every output register holds.
- Error pulses: asserted for exactly the one cycle following the offending acceptance.
- States:
  - IDLE: no burst open.
  - FIXED: SINGLE or a 4/8/16-beat burst in progress.
  - OPEN: undefined-length INCR in progress.
- Per-burst constants:
  - incr = 1 << hsize; len = 1, 4, 8 or 16 (0 = undefined for INCR).
  - Wrap boundary B = len * incr.
  - Latched on NONSEQ: hsize, hburst, hwrite, len, index 0.
- Expected next address, computed at each accepted beat:
  - INCR types: addr + incr, modulo 2^ADDR_W.
  - WRAP types: (addr & ~(B-1)) | ((addr + incr) & (B-1)).
- Accepted NONSEQ:
  - Opens a new burst: beat_first=1, beat_idx=0.
  - beat_last=1 if SINGLE.
  - Next state: FIXED for SINGLE and 4/8/16-beat types, OPEN for INCR.
  - If the previous FIXED burst had not delivered its last beat, pulse err_term.
- Accepted SEQ in FIXED or OPEN:
  - beat_idx increments; beat_first=0; beat_addr = haddr.
  - If haddr differs from the expected address, pulse err_seq; the following expectation is derived from haddr.
  - beat_last=1 when beat_idx == len-1; the next state is then IDLE.
- SEQ in IDLE: err_seq pulse, no beat issued.
- SEQ after a FIXED burst completed: err_term pulse, no beat issued.
- BUSY: no beat, beat_valid=0; burst state, index and expectation are held. BUSY is legal mid-burst, including within OPEN.
- IDLE htrans (or hsel=0) with hready=1: beat_valid=0.
  - From FIXED before the last beat: err_term pulse, state goes to IDLE.
  - From OPEN: normal end of burst, no error.
- err_size: hsize greater than log2(DATA_BYTES) on any accepted transfer pulses err_size; no beat is issued and the state is unchanged.
- beat_idx in OPEN saturates at 2^IDX_W-1; beat_last is always 0 in OPEN.
- INCR crossing a 1 KB boundary is not checked here.
- Simultaneous events: an accepted NONSEQ in the same cycle a FIXED burst is still open reports err_term and starts the new burst in that same cycle. No beat is lost.

Test Plan:
1. WRAP4, word size, NONSEQ 0x1008 then 3 SEQ 0x100C/0x1000/0x1004 -> beat_addr 0x1008,0x100C,0x1000,0x1004; idx 0..3; first on idx0, last on idx3; no errors; state IDLE after.
2. INCR8, halfword, from 0x200 with hready=0 for 2 cycles after beat 2 and one BUSY after beat 5 -> addrs 0x200..0x20E step 2; outputs frozen during stall; beat_valid=0 during BUSY; last on 0x20E.
3. WRAP16, byte size, from 0x3F5 -> beats wrap at 0x3FF to 0x3F0, finishing 0x3F4; last on idx15.
4. INCR4 from 0x40, NONSEQ 0x80 after 2 beats -> err_term pulse; new burst idx0 at 0x80 with beat_first=1.
5. WRAP8 word at 0x20, SEQ with haddr 0x30 where 0x24 expected -> err_seq pulse; next expected address 0x34.
6. hsize=3 with DATA_BYTES=4 -> err_size pulse, beat_valid=0. Then rstn pulse mid-INCR4 -> all outputs 0 immediately; following SEQ -> err_seq.
